// File: rtl/sipo_rr_sched.sv
// Round-robin scheduler sharing one MSB-first SIPO deserializer between NUM_REQ serial lanes.
// Define SIPO_RR_SCHED_PARITY_EN to append an even-parity bit to each shift window and flag mismatches.
module sipo_rr_sched #(
   parameter  int NUM_REQ    = 4,
   parameter  int DATA_WIDTH = 4,
   localparam int ID_W       = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ-1:0]    sin,
   output logic [NUM_REQ-1:0]    grant,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ID_W-1:0]       out_id,
   output logic                  out_perr
);

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t                state_q, state_d;
   logic [ID_W-1:0]       ptr_q, ptr_d;
   logic [ID_W-1:0]       id_q, id_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [NUM_REQ-1:0]    grant_q, grant_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [ID_W-1:0]       out_id_q, out_id_d;
   logic                  out_perr_q, out_perr_d;

   logic                  found;
   logic [ID_W-1:0]       win_id;
   logic                  bit_in;
   logic [DATA_WIDTH-1:0] shifted;
   int                    idx;

   // Scan from the highest offset down so the lowest offset from ptr_q wins.
   always_comb begin
      found  = 1'b0;
      win_id = '0;
      idx    = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (req[idx]) begin
            found  = 1'b1;
            win_id = ID_W'(idx);
         end
      end
   end

   assign bit_in  = sin[id_q];
   assign shifted = {shreg_q[DATA_WIDTH-2:0], bit_in};

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      id_d       = id_q;
      cnt_d      = cnt_q;
      shreg_d    = shreg_q;
      grant_d    = grant_q;
      out_data_d = out_data_q;
      out_id_d   = out_id_q;
      out_perr_d = out_perr_q;
      case (state_q)
         IDLE: begin
            grant_d = '0;
            if (found) begin
               grant_d[win_id] = 1'b1;
               id_d            = win_id;
               cnt_d           = '0;
               shreg_d         = '0;
               state_d         = SHIFT;
            end
         end
         SHIFT: begin
            cnt_d = cnt_q + CNT_W'(1);
`ifdef SIPO_RR_SCHED_PARITY_EN
            // The bit after the data is parity only; it never enters the word.
            if (cnt_q == CNT_W'(DATA_WIDTH)) begin
               cnt_d      = cnt_q;
               grant_d    = '0;
               out_data_d = shreg_q;
               out_id_d   = id_q;
               out_perr_d = (^shreg_q) ^ bit_in;
               state_d    = DONE;
            end else begin
               shreg_d = shifted;
            end
`else
            shreg_d = shifted;
            if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
               grant_d    = '0;
               out_data_d = shifted;
               out_id_d   = id_q;
               state_d    = DONE;
            end
`endif
         end
         DONE: begin
            if (out_ready) begin
               ptr_d   = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         id_q       <= '0;
         cnt_q      <= '0;
         shreg_q    <= '0;
         grant_q    <= '0;
         out_data_q <= '0;
         out_id_q   <= '0;
         out_perr_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         id_q       <= id_d;
         cnt_q      <= cnt_d;
         shreg_q    <= shreg_d;
         grant_q    <= grant_d;
         out_data_q <= out_data_d;
         out_id_q   <= out_id_d;
         out_perr_q <= out_perr_d;
      end
   end

   assign grant     = grant_q;
   assign out_valid = (state_q == DONE);
   assign out_data  = out_data_q;
   assign out_id    = out_id_q;
   assign out_perr  = out_perr_q;

endmodule

// File: tb/tb_sipo_rr_sched.sv
// Scoreboard bench for sipo_rr_sched: directed scenarios then randomized traffic against a word-level model.
// Honors SIPO_RR_SCHED_PARITY_EN the same way as the design.
module tb_sipo_rr_sched;

   localparam int NR = 4;
   localparam int DW = 4;
   localparam int IW = $clog2(NR);
`ifdef SIPO_RR_SCHED_PARITY_EN
   localparam int NBITS = DW + 1;
   localparam bit PAR   = 1'b1;
`else
   localparam int NBITS = DW;
   localparam bit PAR   = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [NR-1:0] req;
   logic [NR-1:0] sin;
   logic [NR-1:0] grant;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [IW-1:0] out_id;
   logic          out_perr;

   sipo_rr_sched #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset(reset), .req(req), .sin(sin), .grant(grant),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_id(out_id), .out_perr(out_perr)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [DW-1:0] d;
      int            id;
      logic          p;
   } exp_t;
   exp_t sb[$];

   // Word-level reference: a lane is either collecting bits, waiting for
   // the consumer, or the scheduler is free to pick the next lane.
   bit            m_active  = 1'b0;
   bit            m_pending = 1'b0;
   int            m_ptr     = 0;
   int            m_id      = 0;
   int            m_n       = 0;
   logic [DW-1:0] m_word    = '0;
   logic [NR-1:0] exp_grant = '0;

   initial begin
      exp_t e;
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            m_active  = 1'b0;
            m_pending = 1'b0;
            m_ptr     = 0;
            sb.delete();
         end else if (m_pending) begin
            if (out_ready) begin
               m_pending = 1'b0;
               m_ptr     = (m_id + 1) % NR;
            end
         end else if (m_active) begin
            if (m_n < DW) m_word[DW-1-m_n] = sin[m_id];
            m_n++;
            if (m_n == NBITS) begin
               e.d  = m_word;
               e.id = m_id;
               e.p  = PAR ? ((^m_word) ^ sin[m_id]) : 1'b0;
               sb.push_back(e);
               m_active  = 1'b0;
               m_pending = 1'b1;
            end
         end else if (req != '0) begin
            for (int k = 0; k < NR; k++) begin
               if (req[(m_ptr + k) % NR]) begin
                  m_id = (m_ptr + k) % NR;
                  break;
               end
            end
            m_active = 1'b1;
            m_n      = 0;
            m_word   = '0;
         end
         exp_grant = '0;
         if (m_active) exp_grant[m_id] = 1'b1;
      end
   end

   // Monitor: compares every cycle on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         chk("grant", 32'(grant), 32'(exp_grant));
         chk("out_valid", 32'(out_valid), 32'(m_pending));
         if (out_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_word", 32'(out_valid), 32'(0));
            end else begin
               chk("out_data", 32'(out_data), 32'(sb[0].d));
               chk("out_id", 32'(out_id), 32'(sb[0].id));
               chk("out_perr", 32'(out_perr), 32'(sb[0].p));
               if (out_ready) begin
                  $display("word id=%0d data=%0h perr=%0b t=%0t", out_id, out_data, out_perr, $time);
                  void'(sb.pop_front());
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; req = '0; sin = '0; out_ready = 1'b0;
      tick(); tick();
      @(negedge clk);
      chk("rst_grant", 32'(grant), 32'(0));
      chk("rst_valid", 32'(out_valid), 32'(0));
      chk("rst_data", 32'(out_data), 32'(0));
      chk("rst_id", 32'(out_id), 32'(0));
      chk("rst_perr", 32'(out_perr), 32'(0));
      tick();
      reset = 1'b0;
      tick();

      // Single requester, bits 1,0,1,1 (then parity 1 when enabled).
      req = 4'b0001;
      tick();
      req = '0;
      sin = 4'b0001; tick();
      sin = 4'b0000; tick();
      sin = 4'b0001; tick();
      sin = 4'b0001; tick();
      if (PAR) begin
         sin = 4'b0001; tick();
      end
      @(negedge clk);
      chk("t1_valid", 32'(out_valid), 32'(1));
      chk("t1_data", 32'(out_data), 32'(4'b1011));
      chk("t1_id", 32'(out_id), 32'(0));
      chk("t1_perr", 32'(out_perr), 32'(0));

      // Backpressure with every lane requesting; no grant may appear.
      req = 4'b1111;
      for (int i = 0; i < 10; i++) begin
         sin = NR'($urandom);
         tick();
      end
      out_ready = 1'b1;
      tick();
      @(negedge clk);
      chk("bp_release", 32'(out_valid), 32'(0));

      // All lanes held: rotating service, words every DW+2 cycles.
      for (int i = 0; i < 6 * (NBITS + 2); i++) begin
         sin = NR'($urandom);
         tick();
      end
      req = '0;
      for (int i = 0; i < 10; i++) tick();

      // Pointer wrap: lane 3 first, then lanes 0 and 3.
      req = 4'b1000;
      tick();
      req = 4'b1001;
      for (int i = 0; i < 3 * (NBITS + 2); i++) begin
         sin = NR'($urandom);
         tick();
      end
      req = '0;
      for (int i = 0; i < 10; i++) tick();

      // Reset on the 2nd shift cycle: grant drops at once, no word follows.
      req = 4'b0010;
      tick();
      req = '0;
      sin = NR'($urandom);
      tick();
      reset = 1'b1;
      #1;
      chk("mid_rst_grant", 32'(grant), 32'(0));
      chk("mid_rst_valid", 32'(out_valid), 32'(0));
      tick();
      reset = 1'b0;
      req = 4'b1111;
      tick();
      @(negedge clk);
      chk("post_rst_grant", 32'(grant), 32'(4'b0001));
      req = '0;
      for (int i = 0; i < 12; i++) tick();

      // Randomized traffic with backpressure and rare resets.
      for (int i = 0; i < 3000; i++) begin
         req       = ($urandom_range(0, 3) == 0) ? '0 : NR'($urandom);
         sin       = NR'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         reset     = ($urandom_range(0, 599) == 0);
         tick();
      end

      reset = 1'b0; req = '0; out_ready = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      @(negedge clk);
      chk("drain_sb", 32'(sb.size()), 32'(0));
      chk("drain_valid", 32'(out_valid), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
